// File: rtl/regfile_loader_if.sv
// Byte-stream handshake feeding the register-file boot loader.
// master drives bytes, slave (the loader) returns ready.
interface regfile_loader_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regfile_loader.sv
// Boot-time sequencer that streams bytes into registers FIRST_REG..LAST_REG.
// Optional running checksum: define REGLOAD_CHECKSUM_EN.
module regfile_loader #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    regfile_loader_if.slave   load,
    input  logic              cpu_we3,
    input  logic [ADDR_W-1:0] cpu_wa3,
    input  logic [DATA_W-1:0] cpu_wd3,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic              we3_q;
    logic [ADDR_W-1:0] wa3_q;
    logic [DATA_W-1:0] wd3_q;
    logic              in_ready;
    logic              hs;
    logic              last;
    logic              go;

    assign load.in_ready = in_ready;
    assign hs            = load.in_valid & in_ready;
    assign last          = (ptr == LAST);
    assign go            = (state == IDLE) & start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (hs && last) state_nx = FLUSH;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Loader owns the port in LOAD/FLUSH; CPU writes are dropped there.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        we3      = cpu_we3;
        wa3      = cpu_wa3;
        wd3      = cpu_wd3;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                we3      = we3_q;
                wa3      = wa3_q;
                wd3      = wd3_q;
            end
            FLUSH: begin
                busy = 1'b1;
                we3  = we3_q;
                wa3  = wa3_q;
                wd3  = wd3_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= FIRST;
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
            done  <= 1'b0;
        end else begin
            done  <= (state == FLUSH);
            we3_q <= hs;
            if (go) ptr <= FIRST;
            if (hs) begin
                wa3_q <= ptr;
                wd3_q <= load.in_data;
                // Final byte leaves ptr parked instead of wrapping.
                if (!last) ptr <= ptr + ADDR_W'(1);
            end
        end
    end

`ifdef REGLOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     sum_q <= '0;
        else if (go) sum_q <= '0;
        else if (hs) sum_q <= sum_q + load.in_data;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: vector table plus reset-mid-load sequence.
module tb_regfile_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cpu_we3;
    logic [2:0] cpu_wa3;
    logic [7:0] cpu_wd3;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    int checks;
    int errors;

    regfile_loader_if #(.DATA_W(8)) lif ();

    regfile_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load     (lif),
        .cpu_we3  (cpu_we3),
        .cpu_wa3  (cpu_wa3),
        .cpu_wd3  (cpu_wd3),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

`ifdef REGLOAD_CHECKSUM_EN
    // 0x11+..+0x77 = 0x1DC ; 0xA1+..+0xA7 = 0x47C
    localparam logic [7:0] CK1 = 8'hDC;
    localparam logic [7:0] CK2 = 8'h7C;
    localparam logic [7:0] CK3 = 8'h44;
`else
    localparam logic [7:0] CK1 = 8'h00;
    localparam logic [7:0] CK2 = 8'h00;
    localparam logic [7:0] CK3 = 8'h00;
`endif

    typedef struct {
        logic       st;
        logic       iv;
        logic [7:0] id;
        logic       cwe;
        logic [2:0] cwa;
        logic [7:0] cwd;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       bsy;
        logic       rdy;
        logic       dn;
        logic       ck;
        logic [7:0] cks;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(
        input logic st, input logic iv, input logic [7:0] id,
        input logic cwe, input logic [2:0] cwa, input logic [7:0] cwd,
        input logic we, input logic [2:0] wa, input logic [7:0] wd,
        input logic bsy, input logic rdy, input logic dn,
        input logic ck, input logic [7:0] cks
    );
        vec_t v;
        v.st = st;   v.iv = iv;   v.id = id;
        v.cwe = cwe; v.cwa = cwa; v.cwd = cwd;
        v.we = we;   v.wa = wa;   v.wd = wd;
        v.bsy = bsy; v.rdy = rdy; v.dn = dn;
        v.ck = ck;   v.cks = cks;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        checks = 0;
        errors = 0;

        // full stream, valid always high
        tbl[0]  = mk(1,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,8'h00);
        tbl[1]  = mk(0,1,8'h11, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[2]  = mk(0,1,8'h22, 0,0,8'h00, 1,1,8'h11, 1,1,0, 0,8'h00);
        tbl[3]  = mk(0,1,8'h33, 0,0,8'h00, 1,2,8'h22, 1,1,0, 0,8'h00);
        tbl[4]  = mk(0,1,8'h44, 0,0,8'h00, 1,3,8'h33, 1,1,0, 0,8'h00);
        tbl[5]  = mk(0,1,8'h55, 0,0,8'h00, 1,4,8'h44, 1,1,0, 0,8'h00);
        tbl[6]  = mk(0,1,8'h66, 0,0,8'h00, 1,5,8'h55, 1,1,0, 0,8'h00);
        tbl[7]  = mk(0,1,8'h77, 0,0,8'h00, 1,6,8'h66, 1,1,0, 0,8'h00);
        tbl[8]  = mk(0,1,8'h88, 0,0,8'h00, 1,7,8'h77, 1,0,0, 0,8'h00);
        tbl[9]  = mk(0,0,8'h00, 1,3,8'hA5, 1,3,8'hA5, 0,0,1, 1,CK1);
        tbl[10] = mk(0,0,8'h00, 1,2,8'h5A, 1,2,8'h5A, 0,0,0, 1,CK1);
        // bubbles, CPU write to r5 and restart pulses during the load
        tbl[11] = mk(1,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 0,8'h00);
        tbl[12] = mk(0,1,8'hA1, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[13] = mk(0,0,8'h00, 0,0,8'h00, 1,1,8'hA1, 1,1,0, 0,8'h00);
        tbl[14] = mk(0,1,8'hA2, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[15] = mk(0,0,8'h00, 1,5,8'hEE, 1,2,8'hA2, 1,1,0, 0,8'h00);
        tbl[16] = mk(0,1,8'hA3, 1,5,8'hEE, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[17] = mk(1,0,8'h00, 0,0,8'h00, 1,3,8'hA3, 1,1,0, 0,8'h00);
        tbl[18] = mk(0,1,8'hA4, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[19] = mk(0,0,8'h00, 0,0,8'h00, 1,4,8'hA4, 1,1,0, 0,8'h00);
        tbl[20] = mk(0,1,8'hA5, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[21] = mk(0,0,8'h00, 0,0,8'h00, 1,5,8'hA5, 1,1,0, 0,8'h00);
        tbl[22] = mk(0,1,8'hA6, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[23] = mk(0,0,8'h00, 0,0,8'h00, 1,6,8'hA6, 1,1,0, 0,8'h00);
        tbl[24] = mk(0,1,8'hA7, 0,0,8'h00, 0,0,8'h00, 1,1,0, 0,8'h00);
        tbl[25] = mk(1,1,8'hA8, 0,0,8'h00, 1,7,8'hA7, 1,0,0, 0,8'h00);
        tbl[26] = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,1, 1,CK2);
        tbl[27] = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,CK2);

        rst          = 1'b1;
        start        = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = 8'h00;
        cpu_we3      = 1'b1;
        cpu_wa3      = 3'd4;
        cpu_wd3      = 8'h3C;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_ready", 32'(lif.in_ready), 32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_cks",   32'(checksum),     32'd0);
        chk("rst_we3",   32'(we3),          32'd1);
        chk("rst_wa3",   32'(wa3),          32'd4);
        chk("rst_wd3",   32'(wd3),          32'h3C);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        cpu_we3 = 1'b0;

        for (int i = 0; i < 28; i++) begin
            @(posedge clk);
            #2;
            start        = tbl[i].st;
            lif.in_valid = tbl[i].iv;
            lif.in_data  = tbl[i].id;
            cpu_we3      = tbl[i].cwe;
            cpu_wa3      = tbl[i].cwa;
            cpu_wd3      = tbl[i].cwd;
            @(negedge clk);
            chk($sformatf("v%0d_we3", i),   32'(we3),          32'(tbl[i].we));
            chk($sformatf("v%0d_busy", i),  32'(busy),         32'(tbl[i].bsy));
            chk($sformatf("v%0d_ready", i), 32'(lif.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_done", i),  32'(done),         32'(tbl[i].dn));
            if (tbl[i].we) begin
                chk($sformatf("v%0d_wa3", i), 32'(wa3), 32'(tbl[i].wa));
                chk($sformatf("v%0d_wd3", i), 32'(wd3), 32'(tbl[i].wd));
            end
            if (tbl[i].ck)
                chk($sformatf("v%0d_cks", i), 32'(checksum), 32'(tbl[i].cks));
        end

        // reset after three bytes, then restart from r1
        @(posedge clk);
        #2;
        start = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk);
            #2;
            start        = 1'b0;
            lif.in_valid = 1'b1;
            lif.in_data  = 8'h31 + 8'(b);
        end
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        lif.in_valid = 1'b0;
        rst          = 1'b1;
        cpu_we3      = 1'b1;
        cpu_wa3      = 3'd6;
        cpu_wd3      = 8'h66;
        #1;
        chk("mrst_busy",  32'(busy),         32'd0);
        chk("mrst_ready", 32'(lif.in_ready), 32'd0);
        chk("mrst_we3",   32'(we3),          32'd1);
        chk("mrst_wa3",   32'(wa3),          32'd6);
        chk("mrst_wd3",   32'(wd3),          32'h66);
        chk("mrst_cks",   32'(checksum),     32'd0);
        chk("mrst_done",  32'(done),         32'd0);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        cpu_we3 = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start        = 1'b0;
        lif.in_valid = 1'b1;
        lif.in_data  = 8'h44;
        @(negedge clk);
        chk("rs_ready", 32'(lif.in_ready), 32'd1);
        chk("rs_we0",   32'(we3),          32'd0);
        @(posedge clk);
        #2;
        lif.in_valid = 1'b0;
        @(negedge clk);
        chk("rs_we3", 32'(we3),      32'd1);
        chk("rs_wa3", 32'(wa3),      32'd1);
        chk("rs_wd3", 32'(wd3),      32'h44);
        chk("rs_cks", 32'(checksum), 32'(CK3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
